// File: rtl/can_crc_tx_if.sv
// ---------------------------------------------------------------------------
// can_crc_tx_if
//   Signal bundle between the transmit frame generator (master) and the
//   transmit CRC engine (slave).
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface can_crc_tx_if;
  logic        tx_point;
  logic        tx_data;
  logic        stuff_bit;
  logic        crc_en;
  logic        initialize;
  logic        fd_frame;
  logic        fd_iso;
  logic [3:0]  dlc;
  logic [2:0]  stuff_count;
  logic        start_crc;
  logic        crc_bit;
  logic        crc_active;
  logic        fixed_stuff;
  logic        crc_done;
  logic [14:0] crc_15;
  logic [16:0] crc_17;
  logic [20:0] crc_21;

  modport master (
    output tx_point, tx_data, stuff_bit, crc_en, initialize, fd_frame, fd_iso,
           dlc, stuff_count, start_crc,
    input  crc_bit, crc_active, fixed_stuff, crc_done, crc_15, crc_17, crc_21
  );

  modport slave (
    input  tx_point, tx_data, stuff_bit, crc_en, initialize, fd_frame, fd_iso,
           dlc, stuff_count, start_crc,
    output crc_bit, crc_active, fixed_stuff, crc_done, crc_15, crc_17, crc_21
  );
endinterface

`default_nettype wire

// File: rtl/can_crc_tx.sv
// ---------------------------------------------------------------------------
// can_crc_tx
//   Transmit-side CAN / CAN FD CRC engine. Accumulates CRC15/17/21 over the
//   transmitted bits and serializes the CRC field (classic CRC15, or FD
//   stuff-count + CRC17/21 with fixed stuff bits).
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module can_crc_tx #(
  parameter logic [14:0] CRC15_POL = 15'h4599,
  parameter logic [16:0] CRC17_POL = 17'h1685B,
  parameter logic [20:0] CRC21_POL = 21'h102899
) (
  input  logic         clk,
  input  logic         rst_n,
  can_crc_tx_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FIELD = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_CLASSIC = 2'd0,
    MODE_FD17    = 2'd1,
    MODE_FD21    = 2'd2
  } mode_t;

  state_t      state, state_nxt;
  mode_t       mode;
  logic [14:0] crc15;
  logic [16:0] crc17;
  logic [20:0] crc21;
  logic        last_bit;   // previous bus bit, source of fixed-stuff value
  logic        iso;        // ISO mode latched at start_crc
  logic [3:0]  sc_bits;    // {gray[2:0], parity}, sent MSB first
  logic [4:0]  bit_idx;    // field-bit index (fixed stuff bits excluded)
  logic [1:0]  grp;        // position inside a group of four FD field bits
  logic        in_stuff;   // current FD slot is a fixed stuff bit

  logic        fd_mode;
  logic        sc_phase;
  logic [4:0]  crc_k;
  logic [4:0]  last_idx;
  logic        last_slot;
  logic        field_out;
  logic        crc_bit, crc_active, fixed_stuff, crc_done;
  logic [2:0]  gray;

  function automatic logic [14:0] step15(input logic [14:0] c, input logic b);
    step15 = {c[13:0], 1'b0} ^ ((b ^ c[14]) ? CRC15_POL : 15'd0);
  endfunction

  function automatic logic [16:0] step17(input logic [16:0] c, input logic b);
    step17 = {c[15:0], 1'b0} ^ ((b ^ c[16]) ? CRC17_POL : 17'd0);
  endfunction

  function automatic logic [20:0] step21(input logic [20:0] c, input logic b);
    step21 = {c[19:0], 1'b0} ^ ((b ^ c[20]) ? CRC21_POL : 21'd0);
  endfunction

  assign fd_mode  = (mode != MODE_CLASSIC);
  assign sc_phase = iso && (bit_idx < 5'd4);
  assign crc_k    = bit_idx - (iso ? 5'd4 : 5'd0);
  assign gray     = {bus.stuff_count[2],
                     bus.stuff_count[2] ^ bus.stuff_count[1],
                     bus.stuff_count[1] ^ bus.stuff_count[0]};

  // Index of the final field bit for the latched frame format
  always_comb begin
    last_idx = 5'd14;
    if (fd_mode) begin
      last_idx = ((mode == MODE_FD21) ? 5'd20 : 5'd16) + (iso ? 5'd4 : 5'd0);
    end
  end

  // Bit presented during FIELD: CRC15, fixed stuff, stuff count or CRC17/21
  always_comb begin
    field_out = 1'b0;
    if (!fd_mode) begin
      field_out = crc15[4'd14 - bit_idx[3:0]];
    end else if (in_stuff) begin
      field_out = ~last_bit;
    end else if (sc_phase) begin
      field_out = sc_bits[2'd3 - bit_idx[1:0]];
    end else if (mode == MODE_FD21) begin
      field_out = crc21[5'd20 - crc_k];
    end else begin
      field_out = crc17[5'd16 - crc_k];
    end
  end

  // A tx_point on this slot ends the field (classic stuff bits do not count)
  assign last_slot = fd_mode ? (!in_stuff && (bit_idx == last_idx))
                             : (!bus.stuff_bit && (bit_idx == last_idx));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and output decode; initialize overrides every state
  always_comb begin
    state_nxt   = state;
    crc_bit     = 1'b0;
    crc_active  = 1'b0;
    fixed_stuff = 1'b0;
    crc_done    = 1'b0;
    case (state)
      S_IDLE: ;
      S_ACCUM: begin
        if (bus.start_crc) state_nxt = S_FIELD;
      end
      S_FIELD: begin
        crc_active  = 1'b1;
        crc_bit     = field_out;
        fixed_stuff = fd_mode && in_stuff;
        if (bus.tx_point && last_slot) state_nxt = S_DONE;
      end
      S_DONE: begin
        crc_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (bus.initialize) state_nxt = S_ACCUM;
  end

  // CRC accumulation, format latching and field position tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc15    <= '0;
      crc17    <= '0;
      crc21    <= '0;
      last_bit <= 1'b0;
      mode     <= MODE_CLASSIC;
      iso      <= 1'b0;
      sc_bits  <= '0;
      bit_idx  <= '0;
      grp      <= '0;
      in_stuff <= 1'b0;
    end else if (bus.initialize) begin
      crc15    <= '0;
      crc17    <= bus.fd_iso ? 17'h10000 : 17'd0;
      crc21    <= bus.fd_iso ? 21'h100000 : 21'd0;
      bit_idx  <= '0;
      grp      <= '0;
      in_stuff <= 1'b0;
    end else begin
      case (state)
        S_ACCUM: begin
          if (bus.tx_point) begin
            last_bit <= bus.tx_data;
            if (bus.crc_en) begin
              if (!bus.stuff_bit) crc15 <= step15(crc15, bus.tx_data);
              crc17 <= step17(crc17, bus.tx_data);
              crc21 <= step21(crc21, bus.tx_data);
            end
          end
          if (bus.start_crc) begin
            if (!bus.fd_frame)          mode <= MODE_CLASSIC;
            else if (bus.dlc > 4'd10)   mode <= MODE_FD21;
            else                        mode <= MODE_FD17;
            iso      <= bus.fd_iso;
            sc_bits  <= {gray, ^gray};
            bit_idx  <= '0;
            grp      <= '0;
            in_stuff <= bus.fd_frame;
          end
        end
        S_FIELD: begin
          if (bus.tx_point) begin
            last_bit <= bus.tx_data;
            if (!fd_mode) begin
              if (!bus.stuff_bit) bit_idx <= bit_idx + 5'd1;
            end else if (in_stuff) begin
              in_stuff <= 1'b0;
            end else begin
              if (sc_phase) begin
                crc17 <= step17(crc17, field_out);
                crc21 <= step21(crc21, field_out);
              end
              bit_idx  <= bit_idx + 5'd1;
              grp      <= grp + 2'd1;
              in_stuff <= (grp == 2'd3);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.crc_bit     = crc_bit;
  assign bus.crc_active  = crc_active;
  assign bus.fixed_stuff = fixed_stuff;
  assign bus.crc_done    = crc_done;
  assign bus.crc_15      = crc15;
  assign bus.crc_17      = crc17;
  assign bus.crc_21      = crc21;

endmodule

`default_nettype wire

// File: tb/tb_can_crc_tx.sv
// ---------------------------------------------------------------------------
// tb_can_crc_tx
//   Self-checking bench for can_crc_tx. CRCs are predicted by polynomial long
//   division; the expected CRC field is built bit by bit from the framing
//   rules and compared slot by slot.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_can_crc_tx;

  localparam logic [31:0] POL15 = 32'h4599;
  localparam logic [31:0] POL17 = 32'h1685B;
  localparam logic [31:0] POL21 = 32'h102899;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   fail_cnt;
  int   total_cnt;
  bit   exp_bit[$];
  bit   exp_fix[$];

  can_crc_tx_if bus ();

  can_crc_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Remainder of (seed*x^L + msg(x)*x^n) mod (x^n + pol), by long division
  function automatic logic [31:0] ref_crc(input int n, input logic [31:0] pol,
                                          input logic [31:0] seed, input bit msg[$]);
    bit          d [0:511];
    int          len;
    logic [31:0] g;
    logic [31:0] r;
    len = msg.size();
    for (int j = 0; j < 512; j++) d[j] = 1'b0;
    for (int j = 0; j < n; j++) d[j] = seed[n-1-j];
    for (int i = 0; i < len; i++) d[i] = d[i] ^ msg[i];
    g = (32'd1 << n) | pol;
    for (int j = 0; j < len; j++)
      if (d[j])
        for (int k = 0; k <= n; k++) d[j+k] = d[j+k] ^ g[n-k];
    r = '0;
    for (int k = 0; k < n; k++) r[n-1-k] = d[len+k];
    return r;
  endfunction

  // One complete frame: seed, data accumulation, CRC field, done pulse
  task automatic run_frame(input bit fd, input bit iso, input logic [3:0] dl,
                           input logic [2:0] sc, input int ndata, input int stuff_pos,
                           input bit combine, input int exp_len);
    bit          q15[$];
    bit          qfd[$];
    bit          fld[$];
    bit          prev;
    logic [31:0] c15, c17, c21, s17, s21, c;
    logic [2:0]  gray;
    int          w, idx, obs_cnt;
    bit          inserted;

    bus.fd_frame    = fd;
    bus.fd_iso      = iso;
    bus.dlc         = dl;
    bus.stuff_count = sc;
    bus.initialize  = 1'b1;
    tick();
    bus.initialize  = 1'b0;
    prev = 1'b0;
    for (int i = 0; i < ndata; i++) begin
      bus.tx_data   = 1'($urandom_range(1, 0));
      bus.stuff_bit = ($urandom_range(4, 0) == 0);
      bus.crc_en    = 1'b1;
      bus.tx_point  = 1'b1;
      bus.start_crc = combine && (i == ndata - 1);
      qfd.push_back(bus.tx_data);
      if (!bus.stuff_bit) q15.push_back(bus.tx_data);
      prev = bus.tx_data;
      tick();
      bus.tx_point  = 1'b0;
      bus.start_crc = 1'b0;
      if ($urandom_range(2, 0) == 0) tick();
    end
    bus.crc_en    = 1'b0;
    bus.stuff_bit = 1'b0;

    s17 = iso ? 32'h10000 : 32'h0;
    s21 = iso ? 32'h100000 : 32'h0;
    c15 = ref_crc(15, POL15, 32'h0, q15);
    c17 = ref_crc(17, POL17, s17, qfd);
    c21 = ref_crc(21, POL21, s21, qfd);
    chk("acc_crc15", 32'(bus.crc_15), c15);
    chk("acc_crc17", 32'(bus.crc_17), c17);
    chk("acc_crc21", 32'(bus.crc_21), c21);

    if (!combine) begin
      bus.start_crc = 1'b1;
      tick();
      bus.start_crc = 1'b0;
    end

    exp_bit.delete();
    exp_fix.delete();
    if (!fd) begin
      for (int k = 14; k >= 0; k--) begin
        exp_bit.push_back(c15[k]);
        exp_fix.push_back(1'b0);
      end
    end else begin
      if (iso) begin
        gray = sc ^ (sc >> 1);
        fld.push_back(gray[2]);
        fld.push_back(gray[1]);
        fld.push_back(gray[0]);
        fld.push_back(^gray);
        for (int k = 0; k < 4; k++) qfd.push_back(fld[k]);
      end
      w = (dl > 4'd10) ? 21 : 17;
      c = (w == 21) ? ref_crc(21, POL21, s21, qfd) : ref_crc(17, POL17, s17, qfd);
      for (int k = w - 1; k >= 0; k--) fld.push_back(c[k]);
      for (int i = 0; i < fld.size(); i++) begin
        if (i % 4 == 0) begin
          exp_bit.push_back(~prev);
          exp_fix.push_back(1'b1);
        end
        exp_bit.push_back(fld[i]);
        exp_fix.push_back(1'b0);
        prev = fld[i];
      end
    end

    idx = 0;
    obs_cnt = 0;
    inserted = 1'b0;
    while (idx < exp_bit.size()) begin
      if (!fd && idx == stuff_pos && !inserted) begin
        chk("stuffed_slot_active", 32'(bus.crc_active), 32'd1);
        bus.stuff_bit = 1'b1;
        bus.tx_data   = 1'($urandom_range(1, 0));
        inserted = 1'b1;
      end else begin
        chk($sformatf("slot%0d_active", idx), 32'(bus.crc_active), 32'd1);
        chk($sformatf("slot%0d_bit", idx), 32'(bus.crc_bit), 32'(exp_bit[idx]));
        chk($sformatf("slot%0d_fixed", idx), 32'(bus.fixed_stuff), 32'(exp_fix[idx]));
        bus.stuff_bit = fd ? 1'($urandom_range(1, 0)) : 1'b0;
        bus.tx_data   = exp_bit[idx];
        idx++;
      end
      if (bus.crc_active) obs_cnt++;
      bus.tx_point = 1'b1;
      tick();
      bus.tx_point  = 1'b0;
      bus.stuff_bit = 1'b0;
      if (idx < exp_bit.size() && $urandom_range(3, 0) == 0) tick();
    end
    chk("field_len", 32'(obs_cnt), 32'(exp_len));
    chk("done_pulse", 32'(bus.crc_done), 32'd1);
    chk("done_inactive", 32'(bus.crc_active), 32'd0);
    chk("done_bit_low", 32'(bus.crc_bit), 32'd0);
    tick();
    chk("done_clear", 32'(bus.crc_done), 32'd0);
  endtask

  initial begin
    bit          one[$];
    logic [3:0]  rdl;
    bit          rfd;
    pass_cnt  = 0;
    fail_cnt  = 0;
    total_cnt = 0;
    one.push_back(1'b1);

    rst_n = 1'b0;
    bus.tx_point = 1'b0;    bus.tx_data = 1'b0;   bus.stuff_bit = 1'b0;
    bus.crc_en = 1'b0;      bus.initialize = 1'b0; bus.fd_frame = 1'b0;
    bus.fd_iso = 1'b0;      bus.dlc = 4'd0;       bus.stuff_count = 3'd0;
    bus.start_crc = 1'b0;
    tick();
    tick();
    chk("rst_active", 32'(bus.crc_active), 32'd0);
    chk("rst_bit", 32'(bus.crc_bit), 32'd0);
    chk("rst_fixed", 32'(bus.fixed_stuff), 32'd0);
    chk("rst_done", 32'(bus.crc_done), 32'd0);
    chk("rst_crc15", 32'(bus.crc_15), 32'd0);
    chk("rst_crc17", 32'(bus.crc_17), 32'd0);
    chk("rst_crc21", 32'(bus.crc_21), 32'd0);
    rst_n = 1'b1;
    tick();

    // IDLE ignores tx_point and start_crc
    bus.tx_point = 1'b1; bus.tx_data = 1'b1; bus.crc_en = 1'b1; bus.start_crc = 1'b1;
    tick();
    bus.tx_point = 1'b0; bus.start_crc = 1'b0;
    chk("idle_ignore_crc17", 32'(bus.crc_17), 32'd0);
    chk("idle_ignore_active", 32'(bus.crc_active), 32'd0);

    // Single '1' from seed 0
    bus.fd_iso = 1'b0; bus.initialize = 1'b1; tick(); bus.initialize = 1'b0;
    bus.tx_point = 1'b1; bus.tx_data = 1'b1; bus.stuff_bit = 1'b0;
    tick();
    bus.tx_point = 1'b0;
    chk("single_one_crc15", 32'(bus.crc_15), 32'h4599);
    chk("single_one_crc21", 32'(bus.crc_21), 32'h102899);

    // Single '1' flagged as a dynamic stuff bit
    bus.initialize = 1'b1; tick(); bus.initialize = 1'b0;
    bus.tx_point = 1'b1; bus.tx_data = 1'b1; bus.stuff_bit = 1'b1;
    tick();
    bus.tx_point = 1'b0; bus.stuff_bit = 1'b0; bus.crc_en = 1'b0;
    chk("stuffed_one_crc15", 32'(bus.crc_15), 32'd0);
    chk("stuffed_one_crc17", 32'(bus.crc_17), 32'h1685B);

    // Directed frames
    run_frame(1'b0, 1'b0, 4'd8,  3'd0, 20, 2,  1'b0, 16);
    run_frame(1'b1, 1'b1, 4'd8,  3'd5, 30, -1, 1'b0, 27);
    run_frame(1'b1, 1'b1, 4'd15, 3'($urandom_range(7, 0)), 40, -1, 1'b1, 32);
    run_frame(1'b1, 1'b0, 4'd9,  3'($urandom_range(7, 0)), 35, -1, 1'b0, 22);
    run_frame(1'b1, 1'b0, 4'd12, 3'($urandom_range(7, 0)), 25, -1, 1'b0, 27);
    run_frame(1'b0, 1'b1, 4'd3,  3'd2, 24, 7,  1'b1, 16);

    // Randomized frames
    for (int f = 0; f < 4; f++) begin
      rfd = 1'($urandom_range(1, 0));
      rdl = 4'($urandom_range(15, 0));
      if (!rfd) begin
        run_frame(1'b0, 1'($urandom_range(1, 0)), rdl, 3'($urandom_range(7, 0)),
                  $urandom_range(40, 10), 14, 1'($urandom_range(1, 0)), 16);
      end else if (f % 2 == 0) begin
        run_frame(1'b1, 1'b1, rdl, 3'($urandom_range(7, 0)), $urandom_range(40, 10),
                  -1, 1'($urandom_range(1, 0)), (rdl > 4'd10) ? 32 : 27);
      end else begin
        run_frame(1'b1, 1'b0, rdl, 3'($urandom_range(7, 0)), $urandom_range(40, 10),
                  -1, 1'($urandom_range(1, 0)), (rdl > 4'd10) ? 27 : 22);
      end
    end

    // initialize during FIELD reseeds and returns to ACCUM
    bus.fd_frame = 1'b1; bus.fd_iso = 1'b1; bus.dlc = 4'd8;
    bus.initialize = 1'b1; tick(); bus.initialize = 1'b0;
    bus.crc_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.tx_point = 1'b1; bus.tx_data = 1'($urandom_range(1, 0)); tick();
    end
    bus.tx_point = 1'b0;
    bus.start_crc = 1'b1; tick(); bus.start_crc = 1'b0;
    chk("reinit_in_field", 32'(bus.crc_active), 32'd1);
    bus.tx_point = 1'b1; bus.tx_data = 1'b1; bus.initialize = 1'b1;
    tick();
    bus.tx_point = 1'b0; bus.initialize = 1'b0;
    chk("reinit_active", 32'(bus.crc_active), 32'd0);
    chk("reinit_crc15", 32'(bus.crc_15), 32'd0);
    chk("reinit_crc17", 32'(bus.crc_17), 32'h10000);
    chk("reinit_crc21", 32'(bus.crc_21), 32'h100000);
    bus.tx_point = 1'b1; bus.tx_data = 1'b1; tick(); bus.tx_point = 1'b0;
    chk("reinit_accum_crc17", 32'(bus.crc_17), ref_crc(17, POL17, 32'h10000, one));
    bus.start_crc = 1'b1; tick(); bus.start_crc = 1'b0;
    chk("reinit_start_field", 32'(bus.crc_active), 32'd1);

    // Asynchronous reset in the middle of the CRC field
    bus.dlc = 4'd15;
    bus.initialize = 1'b1; tick(); bus.initialize = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.tx_point = 1'b1; bus.tx_data = 1'($urandom_range(1, 0)); tick();
    end
    bus.tx_point = 1'b0; bus.crc_en = 1'b0;
    bus.start_crc = 1'b1; tick(); bus.start_crc = 1'b0;
    chk("pre_rst_active", 32'(bus.crc_active), 32'd1);
    chk("pre_rst_fixed", 32'(bus.fixed_stuff), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_active", 32'(bus.crc_active), 32'd0);
    chk("mid_rst_fixed", 32'(bus.fixed_stuff), 32'd0);
    chk("mid_rst_bit", 32'(bus.crc_bit), 32'd0);
    chk("mid_rst_done", 32'(bus.crc_done), 32'd0);
    chk("mid_rst_crc15", 32'(bus.crc_15), 32'd0);
    chk("mid_rst_crc17", 32'(bus.crc_17), 32'd0);
    chk("mid_rst_crc21", 32'(bus.crc_21), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(bus.crc_active), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/can_crc_tx.md
Name: can_crc_tx

Overview:
Transmit-side CRC engine for the CAN/CAN FD controller. It accumulates CRC15, CRC17 and CRC21 over the bits the frame generator sends. At the end of the data field it serializes the CRC field bit by bit:
- Classic frames: the 15-bit CRC sequence.
- FD frames: the stuff-count field (ISO mode only), the CRC17/CRC21 sequence and the fixed stuff bits.
It sits between the transmit frame generator and the bit stuffer. It is the counterpart of the receive-side CRC checker.

Parameters:
CRC15_POL, 15'h4599, CRC15 generator polynomial (x^15 term implicit)
CRC17_POL, 17'h1685B, CRC17 generator polynomial (x^17 term implicit)
CRC21_POL, 21'h102899, CRC21 generator polynomial (x^21 term implicit)

Ports:
clk          in   1   system clock
rst_n        in   1   asynchronous active-low reset
tx_point     in   1   one-cycle strobe, one per transmitted bit time
tx_data      in   1   bit on the bus at this tx_point (includes stuff bits)
stuff_bit    in   1   the tx_point bit is a dynamic stuff bit inserted by the stuffer
crc_en       in   1   accumulate the CRC on tx_point (SOF through end of data)
initialize   in   1   one-cycle pulse at SOF: seed the CRCs and enter ACCUM
fd_frame     in   1   the current frame is CAN FD
fd_iso       in   1   ISO CAN FD mode (stuff-count field, non-zero seeds)
dlc          in   4   data length code of the current frame
stuff_count  in   3   dynamic stuff bits sent so far, binary, mod 8
start_crc    in   1   one-cycle pulse after the last data-bit tx_point
crc_bit      out  1   CRC-field bit to transmit while crc_active
crc_active   out  1   CRC field in progress; frame generator drives crc_bit
fixed_stuff  out  1   crc_bit is a fixed stuff bit (stuffer must not stuff it)
crc_done     out  1   one-cycle pulse after the last CRC-field bit is sent
crc_15       out  15  live CRC15 register
crc_17       out  17  live CRC17 register
crc_21       out  21  live CRC21 register

Behaviour:
Reset:
- rst_n low asynchronously forces state IDLE.
- All outputs and counters go to 0, including the CRC registers.

Priority:
- initialize > start_crc > tx_point activity.
- initialize in any state reseeds the CRCs and enters ACCUM.

Seeds on initialize:
- CRC15 = 0.
- fd_iso=1: CRC17 = 17'h10000, CRC21 = 21'h100000.
- fd_iso=0: CRC17 = 0, CRC21 = 0.

Update rule (on each tx_point):
- next = bit ^ crc[MSB].
- crc = (crc << 1) ^ (next ? POL : 0).
- CRC15 skips bits with stuff_bit=1.
- CRC17 and CRC21 include dynamic stuff bits.

FSM states: IDLE, ACCUM, FIELD, DONE.

IDLE:
- All outputs low.
- Ignores everything except initialize.

ACCUM:
- On tx_point with crc_en=1, update all three CRCs with tx_data.
- last_bit <= tx_data on every tx_point.
- start_crc → FIELD. A tx_point in the same cycle is accumulated first.
- Latch mode at start_crc:
  - classic when fd_frame=0;
  - CRC21 when fd_frame=1 and dlc>10;
  - otherwise CRC17.
- Latch the stuff count at start_crc:
  - gray = {s2, s2^s1, s1^s0};
  - parity = XOR of the three gray bits (even parity over 4 bits).

FIELD, classic:
- crc_active=1.
- crc_bit = CRC15 MSB first, 15 bits.
- Advance on tx_point only when stuff_bit=0; a dynamic stuff bit holds the position.
- fixed_stuff=0.

FIELD, FD:
- Field bits, sent MSB first:
  - ISO: the 4 stuff-count bits, then CRC17/21;
  - non-ISO: the CRC only.
- A fixed stuff bit precedes every field bit with 1-based index ≡ 1 mod 4. No trailing stuff bit.
- On a fixed-stuff slot: crc_bit = ~last_bit and fixed_stuff=1.
- Stuff-count bits are fed into CRC17/21 on their tx_point. The CRC then freezes and shifts out. stuff_bit is ignored in FD.
- Field lengths in tx_points:
  - ISO CRC17: 27;
  - ISO CRC21: 32;
  - non-ISO CRC17: 22;
  - non-ISO CRC21: 27.
- Counters: a 5-bit bit index and a 2-bit group counter.

FIELD exit:
- The tx_point of the last field bit → DONE.

DONE:
- crc_active=0 and crc_done=1 for one cycle, then IDLE.
- start_crc outside ACCUM is ignored.
- crc_bit is 0 whenever crc_active=0.

Test Plan:
1. Classic accumulate, single '1' from seed 0 (crc_en=1, stuff_bit=0) → crc_15 = 15'h4599.
2. Classic accumulate, '1' with stuff_bit=1 → crc_15 unchanged at 0; crc_17 = 17'h1685B (fd_iso=0 seed).
3. Classic serialize, stuff_bit=1 on the 3rd CRC tx_point → crc_active lasts 16 tx_points; the 15 bits equal the latched CRC MSB first; crc_done pulses once.
4. ISO FD, dlc=8, stuff_count=5 → 27 field tx_points.
   - fixed_stuff at positions 0,5,10,15,20,25, each equal to the complement of the previous bit.
   - Stuff-count bits 1,1,1,1 (gray 111, parity 1).
5. ISO FD, dlc=15 → 32 tx_points, fixed_stuff at 0,5,…,30. Non-ISO FD, dlc=9 → 22 tx_points, fixed_stuff at 0,5,10,15,20.
6. Boundary cases:
   - rst_n low mid-FIELD → all outputs 0 immediately.
   - initialize during FIELD → ACCUM with seeds applied.
   - start_crc and tx_point in the same cycle → bit accumulated, then FIELD entered.
